// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM state type,
// derived-size helpers and a parameter legality predicate.
package addsub_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of digit slices needed to cover the full operand width.
    function automatic int calcNdig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; a single-digit configuration still keeps one bit.
    function automatic int calcCntWidth(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

    // Width must split evenly into digits, and a digit cannot exceed the width.
    function automatic bit paramsLegal(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_addsub.sv
// Combinational DIGIT-bit ripple-carry slice. Besides the usual carry-out it
// exposes the carry into its top bit so the caller can form signed overflow
// when this slice handles the most significant digit.
module digit_addsub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] carry;

    // Bit-by-bit ripple: carry[i] enters bit i, carry[i+1] leaves it.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[DIGIT];
    assign cmsb = carry[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit. One DIGIT-wide slice is reused over
// WIDTH/DIGIT cycles with the carry held in a register between digits.
// Subtraction is done as a + ~b + !cin, so the carry-out reads as "no borrow".
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = calcNdig(WIDTH, DIGIT);
    localparam int CNTW = calcCntWidth(NDIG);
    localparam logic [CNTW-1:0] LAST_DIGIT = CNTW'(NDIG - 1);

    if (!paramsLegal(WIDTH, DIGIT)) begin : gBadParams
        $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] resShift_q, resShift_d;
    logic             carry_q, carry_d;
    logic [CNTW-1:0]  digitCnt_q, digitCnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] sliceSum;
    logic             sliceCout;
    logic             sliceCmsb;
    logic [WIDTH-1:0] resNext;
    logic             lastDigit;

    digit_addsub #(
        .DIGIT(DIGIT)
    ) uSlice (
        .a    (opA_q[DIGIT-1:0]),
        .b    (opB_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (sliceSum),
        .cout (sliceCout),
        .cmsb (sliceCmsb)
    );

    // New digits enter at the MSB end so the word is LSB-aligned after NDIG shifts.
    assign resNext   = (resShift_q >> DIGIT) | (WIDTH'(sliceSum) << (WIDTH - DIGIT));
    assign lastDigit = (digitCnt_q == LAST_DIGIT);

    // Next-state logic: accept a request when idle, otherwise step one digit.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        resShift_d = resShift_q;
        carry_d    = carry_q;
        digitCnt_d = digitCnt_q;
        done_d     = 1'b0;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                opA_d      = a;
                opB_d      = b ^ {WIDTH{sub}};
                carry_d    = cin ^ sub;
                digitCnt_d = '0;
                state_d    = ST_RUN;
            end
        end else begin
            opA_d      = opA_q >> DIGIT;
            opB_d      = opB_q >> DIGIT;
            resShift_d = resNext;
            carry_d    = sliceCout;
            if (lastDigit) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                sum_d   = resNext;
                cout_d  = sliceCout;
                ovf_d   = sliceCmsb ^ sliceCout;
                zero_d  = (resNext == '0);
            end else begin
                digitCnt_d = digitCnt_q + CNTW'(1);
            end
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            resShift_q <= '0;
            carry_q    <= 1'b0;
            digitCnt_q <= '0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            resShift_q <= resShift_d;
            carry_q    <= carry_d;
            digitCnt_q <= digitCnt_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (DIGIT = 4, 1, 16) share one
// clock and reset. Accepted requests are scored by a reference model that
// works on plain integers; a monitor pops and compares on every done pulse
// and checks that results hold steady between completions.
module tb_addsub_serial;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    localparam int NDUT = 3;
    localparam int NDIG_V [NDUT] = '{4, 16, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [NDUT];
    logic        sub_v   [NDUT];
    logic [15:0] a_v     [NDUT];
    logic [15:0] b_v     [NDUT];
    logic        cin_v   [NDUT];
    logic        busy_v  [NDUT];
    logic        done_v  [NDUT];
    logic [15:0] sum_v   [NDUT];
    logic        cout_v  [NDUT];
    logic        ovf_v   [NDUT];
    logic        zero_v  [NDUT];

    exp_t sbq [NDUT][$];
    exp_t hold [NDUT];
    logic prevDone [NDUT];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
        .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

    addsub_serial #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
        .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
        .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

    addsub_serial #(.WIDTH(16), .DIGIT(16)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2]), .b(b_v[2]),
        .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
        .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer arithmetic on the operands as unsigned and as signed values.
    function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b,
                                      input logic sub, input logic cin);
        exp_t e;
        int   u;
        int   s;
        if (!sub) begin
            u      = int'(a) + int'(b) + int'(cin);
            s      = int'($signed(a)) + int'($signed(b)) + int'(cin);
            e.cout = (u > 65535);
        end else begin
            u      = int'(a) - int'(b) - int'(cin);
            s      = int'($signed(a)) - int'($signed(b)) - int'(cin);
            e.cout = (u >= 0);
        end
        e.sum  = 16'(u);
        e.ovf  = (s > 32767) || (s < -32768);
        e.zero = (e.sum == 16'h0000);
        e.acc  = 0;
        return e;
    endfunction

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor/scoreboard: compare on done, check hold otherwise, log acceptances.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int k = 0; k < NDUT; k++) begin
                sbq[k].delete();
                hold[k]     = '0;
                prevDone[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (done_v[k]) begin
                    checkOutput($sformatf("dut%0d done repeated", k), 32'(prevDone[k]), 32'd0);
                    checkOutput($sformatf("dut%0d busy in done cycle", k), 32'(busy_v[k]), 32'd0);
                    if (sbq[k].size() == 0) begin
                        checkOutput($sformatf("dut%0d done without request", k), 32'(done_v[k]), 32'd0);
                    end else begin
                        e = sbq[k].pop_front();
                        checkOutput($sformatf("dut%0d sum", k), 32'(sum_v[k]), 32'(e.sum));
                        checkOutput($sformatf("dut%0d cout", k), 32'(cout_v[k]), 32'(e.cout));
                        checkOutput($sformatf("dut%0d ovf", k), 32'(ovf_v[k]), 32'(e.ovf));
                        checkOutput($sformatf("dut%0d zero", k), 32'(zero_v[k]), 32'(e.zero));
                        checkOutput($sformatf("dut%0d latency", k), 32'(cyc - e.acc), 32'(NDIG_V[k]));
                        hold[k] = e;
                    end
                end else begin
                    checkOutput($sformatf("dut%0d result hold", k),
                                32'({sum_v[k], cout_v[k], ovf_v[k], zero_v[k]}),
                                32'({hold[k].sum, hold[k].cout, hold[k].ovf, hold[k].zero}));
                end
                prevDone[k] = done_v[k];
                if (start_v[k] && !busy_v[k]) begin
                    e     = refModel(a_v[k], b_v[k], sub_v[k], cin_v[k]);
                    e.acc = cyc + 1;
                    sbq[k].push_back(e);
                end
            end
        end
    end

    // Issue one request once the instance is idle; start is held for one edge.
    task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
        int guard = 0;
        @(posedge clk); #1;
        while (busy_v[k] && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy_v[k]) checkOutput($sformatf("dut%0d busy timeout", k), 32'(busy_v[k]), 32'd0);
        a_v[k]     = a;
        b_v[k]     = b;
        sub_v[k]   = sub;
        cin_v[k]   = cin;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
    endtask

    task automatic waitIdle(input int k);
        int guard = 0;
        while ((sbq[k].size() != 0 || busy_v[k]) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sbq[k].size() != 0 || busy_v[k])
            checkOutput($sformatf("dut%0d idle timeout", k), 32'(sbq[k].size()), 32'd0);
    endtask

    task automatic checkResetState(input int k, input string tag);
        checkOutput($sformatf("%s dut%0d sum", tag, k), 32'(sum_v[k]), 32'd0);
        checkOutput($sformatf("%s dut%0d cout", tag, k), 32'(cout_v[k]), 32'd0);
        checkOutput($sformatf("%s dut%0d ovf", tag, k), 32'(ovf_v[k]), 32'd0);
        checkOutput($sformatf("%s dut%0d zero", tag, k), 32'(zero_v[k]), 32'd0);
        checkOutput($sformatf("%s dut%0d busy", tag, k), 32'(busy_v[k]), 32'd0);
        checkOutput($sformatf("%s dut%0d done", tag, k), 32'(done_v[k]), 32'd0);
    endtask

    task automatic checkResult(input string tag, input logic [15:0] s, input logic co,
                               input logic ov, input logic z);
        checkOutput({tag, " sum"}, 32'(sum_v[0]), 32'(s));
        checkOutput({tag, " cout"}, 32'(cout_v[0]), 32'(co));
        checkOutput({tag, " ovf"}, 32'(ovf_v[0]), 32'(ov));
        checkOutput({tag, " zero"}, 32'(zero_v[0]), 32'(z));
    endtask

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic randomOps(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(k, pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        waitIdle(k);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        for (int k = 0; k < NDUT; k++) begin
            start_v[k] = 1'b0;
            sub_v[k]   = 1'b0;
            a_v[k]     = '0;
            b_v[k]     = '0;
            cin_v[k]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < NDUT; k++) checkResetState(k, "post-reset");
        repeat (10) @(posedge clk);
        #1;

        applyStimulus(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        waitIdle(0);
        checkResult("add 1234+0FFF", 16'h2233, 1'b0, 1'b0, 1'b0);

        applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitIdle(0);
        checkResult("add FFFF+0001", 16'h0000, 1'b1, 1'b0, 1'b1);

        applyStimulus(0, 16'h0005, 16'h0007, 1'b1, 1'b0);
        waitIdle(0);
        checkResult("sub 0005-0007", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        applyStimulus(0, 16'h8000, 16'h0001, 1'b1, 1'b0);
        waitIdle(0);
        checkResult("sub 8000-0001", 16'h7FFF, 1'b1, 1'b1, 1'b0);

        applyStimulus(0, 16'h0010, 16'h0001, 1'b1, 1'b1);
        waitIdle(0);
        checkResult("sub 0010-0001-1", 16'h000E, 1'b1, 1'b0, 1'b0);

        // A second request while busy must be ignored entirely.
        applyStimulus(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF; sub_v[0] = 1'b1; cin_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        waitIdle(0);
        checkResult("ignored start", 16'h3333, 1'b0, 1'b0, 1'b0);

        // Request raised during the done cycle is taken immediately.
        applyStimulus(0, 16'h0100, 16'h0200, 1'b0, 1'b0);
        guard = 0;
        while (!done_v[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("back-to-back done seen", 32'(done_v[0]), 32'd1);
        a_v[0] = 16'h0003; b_v[0] = 16'h0004; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        waitIdle(0);
        checkResult("back-to-back", 16'h0007, 1'b0, 1'b0, 1'b0);

        // Reset while the third digit is being processed aborts the operation.
        applyStimulus(0, 16'h4444, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) checkResetState(k, "mid-run reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkResetState(0, "after abort");

        applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitIdle(0);
        checkResult("add 7FFF+0001", 16'h8000, 1'b0, 1'b1, 1'b0);

        fork
            randomOps(0, 200);
            randomOps(1, 1000);
            randomOps(2, 1000);
        join

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
